im_loader: RTL and testbench

//   Boot-time writer for the 19-bit instruction memory: receives a byte stream, assembles instructions, writes them to IM.

---
 rtl/im_loader_pkg.sv | 17 +
 rtl/im_loader_if.sv | 30 +++
 rtl/im_loader_asm.sv | 43 ++++
 rtl/im_loader.sv | 141 ++++++++++++++
 tb/tb_im_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and constants for the instruction memory loader
package im_loader_pkg;

  localparam int         BYTES_PER_INST = 3;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_CHK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream input, IM write port and load status bundle
interface im_loader_if #(
  parameter int IM_AW  = 8,
  parameter int INST_W = 19
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_wrt_en;
  logic [IM_AW-1:0]  im_wrt_addr;
  logic [INST_W-1:0] im_wrt_inst;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [IM_AW:0]    words_loaded;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_wrt_en, im_wrt_addr, im_wrt_inst,
    output cpu_hold, load_done, load_err, words_loaded
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_wrt_en, im_wrt_addr, im_wrt_inst,
    input  cpu_hold, load_done, load_err, words_loaded
  );

endinterface

// File: rtl/im_loader_asm.sv
// rtl/im_loader_asm.sv - assembles three little-endian bytes into one instruction word
module im_loader_asm
  import im_loader_pkg::*;
#(
  parameter int INST_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic              word_done,
  output logic [INST_W-1:0] inst
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INST - 1);

  logic [1:0] byte_idx;
  logic [7:0] b0;
  logic [7:0] b1;

  assign word_done = byte_en && (byte_idx == LAST_IDX);

  // The word is latched on the third byte so it is stable during the following write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= 2'd0;
      b0       <= 8'd0;
      b1       <= 8'd0;
      inst     <= '0;
    end else if (clr) begin
      byte_idx <= 2'd0;
    end else if (byte_en) begin
      case (byte_idx)
        2'd0:    b0 <= byte_data;
        2'd1:    b1 <= byte_data;
        default: inst <= {byte_data[INST_W-17:0], b1, b0};
      endcase
      byte_idx <= word_done ? 2'd0 : byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot-time byte-stream loader for the instruction memory
// Optional trailing checksum byte enabled by IM_LOADER_CHECKSUM_EN.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int         IM_AW     = 8,
  parameter int         INST_W    = 19,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input logic        CLK,
  input logic        RESET_N,
  im_loader_if.master bus
);

  localparam logic [IM_AW:0] MAX_WORDS = {1'b1, {IM_AW{1'b0}}};
  localparam logic [IM_AW:0] ONE       = (IM_AW+1)'(1);

  state_t           state;
  state_t           state_n;
  logic             xfer;
  logic             sync_accept;
  logic             byte_en;
  logic             word_done;
  logic             last_word;
  logic [IM_AW:0]   n_total;
  logic [IM_AW:0]   acc_cnt;
  logic [IM_AW:0]   acc_next;
  logic [IM_AW:0]   words_loaded;
  logic [IM_AW-1:0] wr_addr;
  logic             wr_en;
  logic             done_r;
  logic [INST_W-1:0] inst;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]       chk;
  logic             err_r;
`endif

  assign bus.in_ready  = (state != ST_DONE);
  assign xfer          = bus.in_valid && bus.in_ready;
  assign sync_accept   = xfer && (state == ST_IDLE) && (bus.in_data == SYNC_BYTE);
  assign byte_en       = xfer && ((state == ST_B0) || (state == ST_B1) || (state == ST_B2));
  assign acc_next      = acc_cnt + ONE;
  assign last_word     = (acc_next == n_total);

  im_loader_asm #(.INST_W(INST_W)) u_asm (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .clr       (sync_accept),
    .byte_en   (byte_en),
    .byte_data (bus.in_data),
    .word_done (word_done),
    .inst      (inst)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (sync_accept) state_n = ST_CNT;
      ST_CNT:  if (xfer) state_n = ST_B0;
      ST_B0:   if (xfer) state_n = ST_B1;
      ST_B1:   if (xfer) state_n = ST_B2;
      ST_B2: begin
        if (xfer) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_n = last_word ? ST_CHK : ST_B0;
`else
          state_n = last_word ? ST_DONE : ST_B0;
`endif
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CHK:  if (xfer) state_n = (bus.in_data == chk) ? ST_DONE : ST_IDLE;
`endif
      ST_DONE: state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  // The write strobe trails the third byte by one cycle; reset drops it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      n_total      <= '0;
      acc_cnt      <= '0;
      words_loaded <= '0;
      wr_addr      <= '0;
      wr_en        <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      wr_en <= word_done;
      if (word_done) begin
        wr_addr <= acc_cnt[IM_AW-1:0];
        acc_cnt <= acc_next;
      end
      if (wr_en) words_loaded <= words_loaded + ONE;
      if (xfer && (state == ST_CNT))
        n_total <= (bus.in_data == 8'd0) ? MAX_WORDS : (IM_AW+1)'(bus.in_data);
      if (state == ST_DONE) done_r <= 1'b1;
      if (sync_accept) begin
        acc_cnt      <= '0;
        words_loaded <= '0;
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      chk   <= 8'd0;
      err_r <= 1'b0;
    end else begin
      if (sync_accept) begin
        chk   <= 8'd0;
        err_r <= 1'b0;
      end else if (xfer && (state == ST_CNT)) begin
        chk <= bus.in_data;
      end else if (byte_en) begin
        chk <= chk ^ bus.in_data;
      end else if (xfer && (state == ST_CHK) && (bus.in_data != chk)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.load_err = err_r;
`else
  assign bus.load_err = 1'b0;
`endif

  assign bus.im_wrt_en    = wr_en;
  assign bus.im_wrt_addr  = wr_addr;
  assign bus.im_wrt_inst  = inst;
  assign bus.words_loaded = words_loaded;
  assign bus.load_done    = done_r;
  assign bus.cpu_hold     = ~done_r;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized frame stimulus checked against a frame-level reference model
module tb_im_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  im_loader_if #(.IM_AW(8), .INST_W(19)) bus ();

  im_loader dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  frame[$];
  logic [7:0]  mon_addr_q[$];
  logic [18:0] mon_inst_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [18:0] exp_inst_q[$];
  int          exp_words;
  logic        exp_done;
  logic        exp_err;

  always @(negedge clk) begin
    if (rst_n && bus.im_wrt_en) begin
      mon_addr_q.push_back(bus.im_wrt_addr);
      mon_inst_q.push_back(bus.im_wrt_inst);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parse the frame from its byte list: skip junk, read COUNT, pull 3-byte LE words.
  task automatic model_frame();
    int         i;
    int         n;
    logic [7:0] x;
    logic [23:0] w;
    exp_addr_q.delete();
    exp_inst_q.delete();
    i = 0;
    while (i < frame.size() && frame[i] != 8'hA5) i++;
    i++;
    n = (frame[i] == 8'd0) ? 256 : int'(frame[i]);
    x = frame[i];
    i++;
    for (int k = 0; k < n; k++) begin
      w = {frame[i+2], frame[i+1], frame[i]};
      x = x ^ frame[i] ^ frame[i+1] ^ frame[i+2];
      exp_addr_q.push_back(8'(k % 256));
      exp_inst_q.push_back(w[18:0]);
      i += 3;
    end
    exp_words = n;
`ifdef IM_LOADER_CHECKSUM_EN
    exp_err  = (frame[i] != x);
    exp_done = !exp_err;
`else
    exp_err  = 1'b0;
    exp_done = 1'b1;
`endif
  endtask

  task automatic gen_frame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(n));
    x = 8'(n);
    for (int k = 0; k < 3 * n; k++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x = x ^ b;
    end
`ifdef IM_LOADER_CHECKSUM_EN
    frame.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
    if (corrupt) frame.push_back(8'h00);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int waited;
    waited = 0;
    @(negedge clk);
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    else @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, "_nwrites"}, mon_addr_q.size(), exp_addr_q.size());
    m = (mon_addr_q.size() < exp_addr_q.size()) ? mon_addr_q.size() : exp_addr_q.size();
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s_addr%0d", tag, k), mon_addr_q[k], exp_addr_q[k]);
      check($sformatf("%s_inst%0d", tag, k), mon_inst_q[k], exp_inst_q[k]);
    end
    check({tag, "_words"}, bus.words_loaded, exp_words);
    check({tag, "_done"},  bus.load_done, exp_done);
    check({tag, "_err"},   bus.load_err,  exp_err);
    check({tag, "_hold"},  bus.cpu_hold,  !exp_done);
    check({tag, "_ready"}, bus.in_ready,  !exp_done);
  endtask

  task automatic run_frame(input int gap_max, input string tag);
    model_frame();
    mon_addr_q.delete();
    mon_inst_q.delete();
    foreach (frame[k]) send_byte(frame[k], gap_max);
    if (exp_done) begin
      @(negedge clk);
      check({tag, "_done_lag"}, bus.load_done, 0);
`ifndef IM_LOADER_CHECKSUM_EN
      check({tag, "_last_strobe"}, bus.im_wrt_en, 1);
`endif
      @(negedge clk);
      check({tag, "_done_rise"}, bus.load_done, 1);
      check({tag, "_hold_fall"}, bus.cpu_hold, 0);
    end
    repeat (3) @(negedge clk);
    compare(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hold"},  bus.cpu_hold,     1);
    check({tag, "_ready"}, bus.in_ready,     1);
    check({tag, "_wen"},   bus.im_wrt_en,    0);
    check({tag, "_done"},  bus.load_done,    0);
    check({tag, "_err"},   bus.load_err,     0);
    check({tag, "_words"}, bus.words_loaded, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    do_reset("reset");

    frame = '{8'hA5, 8'h02, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07};
`ifdef IM_LOADER_CHECKSUM_EN
    frame.push_back(8'h62);
`endif
    run_frame(0, "good");
    if (mon_inst_q.size() >= 2) begin
      check("good_w0", mon_inst_q[0], 19'h12345);
      check("good_w1", mon_inst_q[1], 19'h7FFFF);
    end

`ifdef IM_LOADER_CHECKSUM_EN
    do_reset("rst_bad");
    frame = '{8'hA5, 8'h02, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07, 8'h00};
    run_frame(1, "badchk");
    frame = '{8'hA5, 8'h02, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07, 8'h62};
    run_frame(1, "recover");
`endif

    do_reset("rst_junk");
    frame = '{8'h00, 8'h11, 8'hA4, 8'hA5, 8'h02, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07};
`ifdef IM_LOADER_CHECKSUM_EN
    frame.push_back(8'h62);
`endif
    run_frame(3, "junk");

    for (int r = 0; r < 4; r++) begin
      do_reset($sformatf("rst_rnd%0d", r));
`ifdef IM_LOADER_CHECKSUM_EN
      gen_frame($urandom_range(1, 6), 1'b1);
      run_frame(2, $sformatf("rnd_bad%0d", r));
`endif
      gen_frame($urandom_range(1, 6), 1'b0);
      run_frame(2, $sformatf("rnd%0d", r));
    end

    do_reset("rst_full");
    gen_frame(256, 1'b0);
    run_frame(0, "full");

    do_reset("rst_mid");
    mon_addr_q.delete();
    mon_inst_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h45, 0);
    send_byte(8'h23, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_async");
    repeat (3) @(negedge clk);
    check("mid_nowrite", mon_addr_q.size(), 0);
    rst_n = 1'b1;
    frame = '{8'hA5, 8'h01, 8'h45, 8'h23, 8'h01};
`ifdef IM_LOADER_CHECKSUM_EN
    frame.push_back(8'h66);
`endif
    run_frame(1, "fresh");
    if (mon_addr_q.size() >= 1) begin
      check("fresh_addr0", mon_addr_q[0], 8'h00);
      check("fresh_inst0", mon_inst_q[0], 19'h12345);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
